// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: decode-side queue head, redirect/halt control and the
// single-outstanding instruction-memory handshake.
interface fetch_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              halt;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_ready;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc_plus;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_done;
    logic [DATA_W-1:0] mem_data;
    logic              mem_err;
    logic              err;

    modport master (
        input  halt, redirect, redirect_pc, inst_ready, mem_done, mem_data, mem_err,
        output inst_valid, inst, inst_pc_plus, mem_rd, mem_addr, err
    );

    modport slave (
        output halt, redirect, redirect_pc, inst_ready, mem_done, mem_data, mem_err,
        input  inst_valid, inst, inst_pc_plus, mem_rd, mem_addr, err
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: walks the PC with one outstanding memory read and buffers
// {word, pc+INC} in a DEPTH-entry FIFO; redirects flush and squash in-flight reads.
module fetch_queue #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                INC      = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] INC_A   = ADDR_W'(INC);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic              r_err;
    logic [DATA_W-1:0] r_data_q [DEPTH];
    logic [ADDR_W-1:0] r_pcp_q  [DEPTH];

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_start;
    logic              w_misalign;
    logic              w_resp_err;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] w_req_addr_nxt;

    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & bus.inst_ready & ~bus.redirect;
    assign w_push     = (r_state == ST_REQ) & bus.mem_done & ~bus.redirect;
    assign w_cnt_nxt  = bus.redirect ? '0 : r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // Occupancy after this edge decides issue, so a same-cycle pop frees a slot.
    assign w_start    = ~bus.halt & (w_cnt_nxt < DEPTH_C);
    assign w_misalign = (bus.redirect_pc % INC_A) != '0;
    assign w_resp_err = (r_state == ST_REQ) & bus.mem_done & bus.mem_err;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        // NOTE: combinational blocks use blocking '='; clocked blocks below use '<='.
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_addr_nxt = r_req_addr;
        case (r_state)
            ST_IDLE: begin
                if (bus.redirect) begin
                    w_fetch_pc_nxt = bus.redirect_pc;
                end else if (w_start) begin
                    w_state_nxt    = ST_REQ;
                    w_req_addr_nxt = r_fetch_pc;
                end
            end
            ST_REQ: begin
                if (bus.redirect) begin
                    w_fetch_pc_nxt = bus.redirect_pc;
                    w_state_nxt    = bus.mem_done ? ST_IDLE : ST_DROP;
                end else if (bus.mem_done) begin
                    w_fetch_pc_nxt = r_fetch_pc + INC_A;
                    if (w_start) begin
                        w_req_addr_nxt = r_fetch_pc + INC_A;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (bus.redirect) begin
                    w_fetch_pc_nxt = bus.redirect_pc;
                end
                if (bus.mem_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            if (w_resp_err || (bus.redirect && w_misalign)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= w_cnt_nxt;
            if (bus.redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: queue storage is not reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_q[r_wr_ptr] <= bus.mem_data;
            r_pcp_q[r_wr_ptr]  <= r_req_addr + INC_A;
        end
    end

    assign bus.inst_valid   = w_valid;
    assign bus.inst         = r_data_q[r_rd_ptr];
    assign bus.inst_pc_plus = r_pcp_q[r_rd_ptr];
    assign bus.mem_rd       = (r_state != ST_IDLE);
    assign bus.mem_addr     = r_req_addr;
    assign bus.err          = r_err;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, with decode-side
// output checked against the architectural instruction stream from each redirect.
module tb_fetch_queue;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int INC    = 2;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int lat      = 0;
    int err_req  = 0;

    // Reference model state: PC of the next instruction decode should receive.
    logic [15:0] m_exp_pc = 16'h0000;

    fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fetch_queue #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .INC     (INC),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [31:0] p;
        p = {16'h0000, a} * 32'h0000_9E37;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Memory: completes each read after lat extra wait cycles (lat=0: same cycle as rd).
    initial begin : responder
        int cnt;
        int err_ack;
        cnt = 0;
        err_ack = 0;
        bus.mem_done = 1'b0;
        bus.mem_data = '0;
        bus.mem_err  = 1'b0;
        forever begin
            step();
            if (rst && bus.mem_rd) begin
                if (cnt >= lat) begin
                    bus.mem_done = 1'b1;
                    bus.mem_data = mem_word(bus.mem_addr);
                    bus.mem_err  = (err_req != err_ack);
                    err_ack      = err_req;
                    cnt          = 0;
                end else begin
                    bus.mem_done = 1'b0;
                    bus.mem_data = 16'($urandom);
                    bus.mem_err  = 1'b0;
                    cnt++;
                end
            end else begin
                bus.mem_done = 1'b0;
                bus.mem_err  = 1'b0;
                cnt = 0;
            end
        end
    end

    // Decode-side model: pops must follow the straight-line stream from the last redirect.
    initial begin : monitor
        logic        prev_rd;
        logic        prev_done;
        logic        prev_rst;
        logic [15:0] prev_addr;
        logic [15:0] exp_pp;
        prev_rd = 1'b0;
        prev_done = 1'b0;
        prev_rst = 1'b0;
        prev_addr = '0;
        forever begin
            mid();
            if (!rst) begin
                m_exp_pc = 16'h0000;
            end else begin
                if (bus.redirect) begin
                    m_exp_pc = bus.redirect_pc;
                end else if (bus.inst_valid && bus.inst_ready) begin
                    exp_pp = m_exp_pc + 16'd2;
                    check("pop_pc_plus", 32'(bus.inst_pc_plus), 32'(exp_pp));
                    check("pop_inst", 32'(bus.inst), 32'(mem_word(m_exp_pc)));
                    m_exp_pc = exp_pp;
                end
                if (prev_rst && prev_rd && !prev_done) begin
                    check("rd_held", 32'(bus.mem_rd), 32'd1);
                    check("addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
                end
            end
            prev_rd   = bus.mem_rd;
            prev_done = bus.mem_done;
            prev_rst  = rst;
            prev_addr = bus.mem_addr;
        end
    end

    initial begin : main
        int          n_done;
        logic        ok;
        logic [15:0] exp_a;

        rst             = 1'b1;
        bus.halt        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b1;
        #2 rst = 1'b0;
        mid();
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        repeat (2) step();
        rst = 1'b1;

        // Zero-wait streaming from reset PC.
        mid();
        check("t1_idle_rd", 32'(bus.mem_rd), 32'd0);
        step(); mid();
        check("t1_first_rd", 32'(bus.mem_rd), 32'd1);
        check("t1_first_addr", 32'(bus.mem_addr), 32'h0);
        check("t1_first_valid", 32'(bus.inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); mid();
            check("t1_valid", 32'(bus.inst_valid), 32'd1);
            check("t1_pc_plus", 32'(bus.inst_pc_plus), 32'(2 * (i + 1)));
            check("t1_addr", 32'(bus.mem_addr), 32'(2 * (i + 1)));
        end

        // Decode stalled: queue fills with exactly DEPTH entries, then drains in order.
        step();
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0000;
        mid();
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            bus.redirect = 1'b0;
            mid();
            if (bus.mem_rd && bus.mem_done) n_done++;
        end
        check("t2_pushes", 32'(n_done), 32'(DEPTH));
        check("t2_rd_stopped", 32'(bus.mem_rd), 32'd0);
        check("t2_head_pc", 32'(bus.inst_pc_plus), 32'h2);
        check("t2_head_inst", 32'(bus.inst), 32'(mem_word(16'h0000)));
        step();
        bus.inst_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mid();
            if (bus.mem_rd) begin ok = 1'b1; break; end
            step();
        end
        check("t2_resume_seen", 32'(ok), 32'd1);
        check("t2_resume_addr", 32'(bus.mem_addr), 32'h8);

        // Slow memory, redirect during a wait cycle: stale word dropped.
        step();
        bus.halt = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            mid();
            if (!bus.mem_rd && !bus.inst_valid) begin ok = 1'b1; break; end
            step();
        end
        check("t3_drained", 32'(ok), 32'd1);
        step();
        lat = 2;
        bus.halt = 1'b0;
        mid();
        check("t3_idle", 32'(bus.mem_rd), 32'd0);
        step(); mid();
        check("t3_wait1_rd", 32'(bus.mem_rd), 32'd1);
        check("t3_wait1_done", 32'(bus.mem_done), 32'd0);
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        mid();
        check("t3_wait2_done", 32'(bus.mem_done), 32'd0);
        step();
        bus.redirect = 1'b0;
        mid();
        check("t3_drop_rd", 32'(bus.mem_rd), 32'd1);
        check("t3_drop_done", 32'(bus.mem_done), 32'd1);
        step(); mid();
        check("t3_stale_valid", 32'(bus.inst_valid), 32'd0);
        check("t3_after_drop_rd", 32'(bus.mem_rd), 32'd0);
        step(); mid();
        check("t3_new_rd", 32'(bus.mem_rd), 32'd1);
        check("t3_new_addr", 32'(bus.mem_addr), 32'h0040);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(); mid();
            if (bus.inst_valid) begin ok = 1'b1; break; end
        end
        check("t3_first_seen", 32'(ok), 32'd1);
        check("t3_first_pc", 32'(bus.inst_pc_plus), 32'h0042);

        // Redirect with a pop in the same cycle empties the queue.
        step();
        lat = 0;
        bus.inst_ready = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            mid();
            if (!bus.mem_rd && bus.inst_valid) begin ok = 1'b1; break; end
            step();
        end
        check("t4_full", 32'(ok), 32'd1);
        step();
        bus.inst_ready = 1'b1;
        mid();
        check("t4_full_valid", 32'(bus.inst_valid), 32'd1);
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        mid();
        check("t4_cnt3_valid", 32'(bus.inst_valid), 32'd1);
        check("t4_cnt3_rd", 32'(bus.mem_rd), 32'd1);
        step();
        bus.redirect = 1'b0;
        mid();
        check("t4_flushed_valid", 32'(bus.inst_valid), 32'd0);
        check("t4_flushed_rd", 32'(bus.mem_rd), 32'd0);

        // Halt during a live read: the word still lands, then fetch stops.
        step();
        bus.halt = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            mid();
            if (!bus.mem_rd && !bus.inst_valid) begin ok = 1'b1; break; end
            step();
        end
        check("t5_drained", 32'(ok), 32'd1);
        step();
        bus.inst_ready = 1'b0;
        lat = 2;
        bus.halt = 1'b0;
        mid();
        step();
        bus.halt = 1'b1;
        mid();
        check("t5_live_rd", 32'(bus.mem_rd), 32'd1);
        step(); mid();
        step(); mid();
        check("t5_done", 32'(bus.mem_done), 32'd1);
        step(); mid();
        exp_a = m_exp_pc + 16'd2;
        check("t5_enq_valid", 32'(bus.inst_valid), 32'd1);
        check("t5_enq_pc", 32'(bus.inst_pc_plus), 32'(exp_a));
        check("t5_enq_inst", 32'(bus.inst), 32'(mem_word(m_exp_pc)));
        check("t5_no_rd", 32'(bus.mem_rd), 32'd0);
        repeat (3) begin
            step(); mid();
            check("t5_halted_rd", 32'(bus.mem_rd), 32'd0);
        end
        step();
        bus.halt = 1'b0;
        mid();
        step(); mid();
        check("t5_resume_rd", 32'(bus.mem_rd), 32'd1);
        check("t5_resume_addr", 32'(bus.mem_addr), 32'(exp_a));
        step();
        bus.inst_ready = 1'b1;

        // Random traffic against the stream model.
        for (int k = 0; k < 400; k++) begin
            step();
            bus.inst_ready  = ($urandom_range(0, 9) < 7);
            bus.halt        = ($urandom_range(0, 9) == 0);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
            mid();
        end
        step();
        bus.redirect   = 1'b0;
        bus.halt       = 1'b0;
        bus.inst_ready = 1'b1;
        lat = 0;
        mid();
        check("rand_err_clear", 32'(bus.err), 32'd0);

        // Sticky error from a faulting response, then from a misaligned redirect.
        repeat (4) begin step(); mid(); end
        step();
        err_req++;
        ok = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mid();
            if (bus.err) begin ok = 1'b1; break; end
            step();
        end
        check("t6_mem_err", 32'(ok), 32'd1);
        repeat (5) begin step(); mid(); end
        check("t6_err_sticky", 32'(bus.err), 32'd1);
        step();
        rst = 1'b0;
        mid();
        check("t6_rst_err", 32'(bus.err), 32'd0);
        check("t6_rst_rd", 32'(bus.mem_rd), 32'd0);
        step();
        rst = 1'b1;
        mid();
        check("t6_post_rst_err", 32'(bus.err), 32'd0);
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0011;
        mid();
        step();
        bus.redirect = 1'b0;
        mid();
        check("t6_misalign_err", 32'(bus.err), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(); mid();
            if (bus.inst_valid) begin ok = 1'b1; break; end
        end
        check("t6_fetch_continues", 32'(ok), 32'd1);
        check("t6_first_pc", 32'(bus.inst_pc_plus), 32'h0013);
        check("t6_err_held", 32'(bus.err), 32'd1);
        repeat (3) begin step(); mid(); end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        if (n_fail > 0) $display("FAIL summary: %0d comparisons did not hold", n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
